calc_hist: RTL and testbench

Parametrised accumulator calculator, successor to the fixed 16-bit button/switch calculator. Each operation combines the accumulator with the switch operand:
- Generic `WIDTH`.
- 4-bit op code, adding a sequential shift-add multiplier, load and extra shifts.
- Rising-edge detection on the enter and undo buttons.
- A `DEPTH`-entry undo history.
- Overflow and zero flags.

It sits between the debounced board buttons/switches and the LED driver.

---
 rtl/calc_hist_if.sv | 30 +++
 rtl/calc_hist.sv | 184 ++++++++++++++++++
 tb/tb_calc_hist.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_hist_if.sv
// Board-side bundle for calc_hist: debounced buttons and switches in,
// accumulator, flags and history depth out.
interface calc_hist_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic             btnd;
  logic             btnz;
  logic             btnx;
  logic             btnl;
  logic             btnc;
  logic             btnr;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] led;
  logic             busy;
  logic             ovf;
  logic             zero;
  logic [CW-1:0]    hist_cnt;

  modport master (
    output btnd, btnz, btnx, btnl, btnc, btnr, sw,
    input  led, busy, ovf, zero, hist_cnt
  );

  modport slave (
    input  btnd, btnz, btnx, btnl, btnc, btnr, sw,
    output led, busy, ovf, zero, hist_cnt
  );
endinterface

// File: rtl/calc_hist.sv
// Accumulator calculator with edge-triggered enter/undo, a circular LIFO undo
// history and a sequential shift-add multiplier.
module calc_hist #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic       clk,
  input  logic       btnu,
  calc_hist_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_LOAD = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1011;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q, state_d;
  logic               btnd_q, btnz_q;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      top_q, top_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SHW-1:0]     step_q, step_d;

  logic [WIDTH-1:0]   hist_mem [DEPTH];
  logic               push;

  logic [3:0]         op;
  logic [SHW-1:0]     sh;
  logic               enter, undo;
  logic [PW-1:0]      top_next, top_prev;
  logic [WIDTH-1:0]   sum, diff;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [2*WIDTH-1:0] prod_sum;

  assign op       = {bus.btnx, bus.btnl, bus.btnc, bus.btnr};
  assign sh       = bus.sw[SHW-1:0];
  assign enter    = bus.btnd & ~btnd_q;
  assign undo     = bus.btnz & ~btnz_q;
  // top_q points at the slot the next push writes; the newest entry sits one below.
  assign top_next = (top_q == PW'(DEPTH - 1)) ? '0 : top_q + PW'(1);
  assign top_prev = (top_q == '0) ? PW'(DEPTH - 1) : top_q - PW'(1);
  assign sum      = acc_q + bus.sw;
  assign diff     = acc_q - bus.sw;
  assign rot      = {acc_q, acc_q} << sh;
  assign prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = acc_q;
    alu_ovf = 1'b0;
    case (op)
      OP_AND:  alu_res = acc_q & bus.sw;
      OP_OR:   alu_res = acc_q | bus.sw;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (acc_q[WIDTH-1] == bus.sw[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (acc_q[WIDTH-1] != bus.sw[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(acc_q) < $signed(bus.sw))};
      OP_SLL:  alu_res = acc_q << sh;
      OP_SRA:  alu_res = $signed(acc_q) >>> sh;
      OP_XOR:  alu_res = acc_q ^ bus.sw;
      OP_LOAD: alu_res = bus.sw;
      OP_SRL:  alu_res = acc_q >> sh;
      OP_ROL:  alu_res = rot[2*WIDTH-1:WIDTH];
      default: alu_res = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    top_d    = top_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    step_d   = step_q;
    push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Enter takes priority; a coincident undo is dropped even for a NOP.
        if (enter) begin
          if (op[3:2] != 2'b11) begin
            push  = 1'b1;
            top_d = top_next;
            cnt_d = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + CW'(1);
            if (op == OP_MUL) begin
              state_d  = S_MUL;
              mcand_d  = {{WIDTH{1'b0}}, acc_q};
              mplier_d = bus.sw;
              prod_d   = '0;
              step_d   = '0;
            end else begin
              acc_d = alu_res;
              ovf_d = alu_ovf;
            end
          end
        end else if (undo && (cnt_q != '0)) begin
          acc_d = hist_mem[top_prev];
          top_d = top_prev;
          cnt_d = cnt_q - CW'(1);
          ovf_d = 1'b0;
        end
      end
      S_MUL: begin
        prod_d   = prod_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + SHW'(1);
        if (step_q == SHW'(WIDTH - 1)) begin
          acc_d   = prod_sum[WIDTH-1:0];
          ovf_d   = |prod_sum[2*WIDTH-1:WIDTH];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (btnu) begin
      state_q  <= S_IDLE;
      btnd_q   <= 1'b0;
      btnz_q   <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      top_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      btnd_q   <= bus.btnd;
      btnz_q   <= bus.btnz;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      top_q    <= top_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      step_q   <= step_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      hist_mem[top_q] <= acc_q;
    end
  end

  assign bus.led      = acc_q;
  assign bus.busy     = (state_q == S_MUL);
  assign bus.ovf      = ovf_q;
  assign bus.zero     = (acc_q == '0);
  assign bus.hist_cnt = cnt_q;

endmodule

// File: tb/tb_calc_hist.sv
// Directed bench for calc_hist (WIDTH=16, DEPTH=4) with hand-computed results.
module tb_calc_hist;
  localparam int W = 16;
  localparam int D = 4;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_LOAD = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1011;

  logic clk = 1'b0;
  logic btnu;
  int   n_checks = 0;
  int   n_errors = 0;

  calc_hist_if #(.WIDTH(W), .DEPTH(D)) bus ();

  calc_hist #(.WIDTH(W), .DEPTH(D)) dut (
    .clk  (clk),
    .btnu (btnu),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [W-1:0] b);
    {bus.btnx, bus.btnl, bus.btnc, bus.btnr} = op;
    bus.sw = b;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] b);
    set_op(op, b);
    bus.btnd = 1'b1;
    tick();
    bus.btnd = 1'b0;
    tick();
  endtask

  task automatic do_undo();
    bus.btnz = 1'b1;
    tick();
    bus.btnz = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    btnu = 1'b1;
    tick();
    tick();
    btnu = 1'b0;
    tick();
  endtask

  int busy_cycles;
  int led_bad;

  initial begin
    btnu = 1'b1;
    bus.btnd = 1'b0;
    bus.btnz = 1'b0;
    set_op(OP_NOP_DEFAULT(), '0);
    do_reset();
    check("rst_led", bus.led, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_cnt", bus.hist_cnt, 0);
    check("rst_zero", bus.zero, 1);

    // Scenario 1: basic ops fill the history
    do_op(OP_ADD, 16'h354A); check("s1_add", bus.led, 16'h354A);
    do_op(OP_SUB, 16'h1234); check("s1_sub", bus.led, 16'h2316);
    do_op(OP_OR,  16'h1001); check("s1_or",  bus.led, 16'h3317);
    do_op(OP_AND, 16'hF0F0); check("s1_and", bus.led, 16'h3010);
    check("s1_cnt", bus.hist_cnt, 4);
    check("s1_ovf", bus.ovf, 0);

    // Scenario 4: overflowing history, undo to empty, enter beats undo
    do_op(OP_ADD, 16'h0001); check("s4_add", bus.led, 16'h3011);
    check("s4_cnt_full", bus.hist_cnt, 4);
    do_undo(); check("s4_undo1", bus.led, 16'h3010);
    do_undo(); check("s4_undo2", bus.led, 16'h3317);
    do_undo(); check("s4_undo3", bus.led, 16'h2316);
    do_undo(); check("s4_undo4", bus.led, 16'h354A);
    do_undo(); check("s4_undo5", bus.led, 16'h354A);
    check("s4_cnt_empty", bus.hist_cnt, 0);
    set_op(OP_ADD, 16'h0001);
    bus.btnd = 1'b1;
    bus.btnz = 1'b1;
    tick();
    bus.btnd = 1'b0;
    bus.btnz = 1'b0;
    check("s4_both_led", bus.led, 16'h354B);
    check("s4_both_cnt", bus.hist_cnt, 1);
    tick();

    // Scenario 2: held enter fires once
    do_reset();
    set_op(OP_ADD, 16'h0001);
    bus.btnd = 1'b1;
    repeat (5) tick();
    check("s2_hold_led", bus.led, 16'h0001);
    check("s2_hold_cnt", bus.hist_cnt, 1);
    bus.btnd = 1'b0;
    tick();
    bus.btnd = 1'b1;
    tick();
    bus.btnd = 1'b0;
    check("s2_repress", bus.led, 16'h0002);
    tick();

    // Scenario 3: multiply with an ignored enter while busy
    do_reset();
    do_op(OP_LOAD, 16'h0123); check("s3_load", bus.led, 16'h0123);
    set_op(OP_MUL, 16'h0100);
    bus.btnd = 1'b1;
    tick();
    bus.btnd = 1'b0;
    check("s3_commit_busy", bus.busy, 1);
    check("s3_commit_cnt", bus.hist_cnt, 2);
    busy_cycles = 1;
    led_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin
        set_op(OP_ADD, 16'hFFFF);
        bus.btnd = 1'b1;
      end
      if (k == 4) bus.btnd = 1'b0;
      tick();
      if (bus.busy) begin
        busy_cycles++;
        if (bus.led !== 16'h0123) led_bad++;
      end else begin
        break;
      end
    end
    check("s3_busy_cycles", busy_cycles, 16);
    check("s3_led_steady", led_bad, 0);
    check("s3_mul_led", bus.led, 16'h2300);
    check("s3_mul_ovf", bus.ovf, 1);
    check("s3_busy_low", bus.busy, 0);
    check("s3_cnt", bus.hist_cnt, 2);

    // Scenario 5: signed overflow, SLT, zero flag
    do_reset();
    do_op(OP_LOAD, 16'h7FFF);
    do_op(OP_ADD, 16'h0001); check("s5_add", bus.led, 16'h8000);
    check("s5_add_ovf", bus.ovf, 1);
    do_op(OP_SLT, 16'h0000); check("s5_slt", bus.led, 16'h0001);
    check("s5_slt_ovf", bus.ovf, 0);
    check("s5_slt_zero", bus.zero, 0);
    do_op(OP_AND, 16'h0000); check("s5_and", bus.led, 16'h0000);
    check("s5_and_zero", bus.zero, 1);

    // Shift/rotate/xor chain
    do_op(OP_LOAD, 16'h8001);
    do_op(OP_SRA, 16'h0004); check("sh_sra", bus.led, 16'hF800);
    do_op(OP_ROL, 16'h0004); check("sh_rol", bus.led, 16'h800F);
    do_op(OP_SRL, 16'h0004); check("sh_srl", bus.led, 16'h0800);
    do_op(OP_SLL, 16'h0004); check("sh_sll", bus.led, 16'h8000);
    do_op(OP_XOR, 16'h00FF); check("sh_xor", bus.led, 16'h80FF);
    do_op(4'b1100, 16'hFFFF); check("nop_led", bus.led, 16'h80FF);
    check("nop_cnt", bus.hist_cnt, 4);

    // Scenario 6: reset aborts an in-flight multiply
    do_reset();
    do_op(OP_LOAD, 16'h00FF);
    set_op(OP_MUL, 16'h0003);
    bus.btnd = 1'b1;
    tick();
    bus.btnd = 1'b0;
    repeat (4) tick();
    check("s6_busy_mid", bus.busy, 1);
    btnu = 1'b1;
    tick();
    check("s6_led", bus.led, 0);
    check("s6_busy", bus.busy, 0);
    check("s6_cnt", bus.hist_cnt, 0);
    check("s6_ovf", bus.ovf, 0);
    btnu = 1'b0;
    tick();
    do_undo();
    check("s6_undo_led", bus.led, 0);
    check("s6_undo_cnt", bus.hist_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic logic [3:0] OP_NOP_DEFAULT();
    return 4'b1111;
  endfunction

endmodule
